// File: rtl/fpmul_arbiter_if.sv
// Requester-side bus of the shared FP multiplier arbiter: per-requester operands and grant,
// plus the registered one-hot result strobe and result data.
interface fpmul_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0][XLEN-1:0] req_a;
    logic [N_REQ-1:0][XLEN-1:0] req_b;
    logic [N_REQ-1:0]           rsp_valid;
    logic [XLEN-1:0]            rsp_data;

    modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one LAT-cycle pipelined FP multiplier among N_REQ requesters.
// Optional macro FPARB_PERF_EN adds saturating issue/stall performance counters.
module fpmul_arbiter #(
    parameter int N_REQ = 3,
    parameter int LAT   = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    fpmul_arbiter_if.slave  req_if,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_result,
    output logic            idle
`ifdef FPARB_PERF_EN
    ,
    output logic [31:0]     perf_issue_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]          ptr;
    logic [IW-1:0]          gnt_idx;
    logic [IW-1:0]          scan_idx;
    logic                   gnt_found;
    logic                   xfer;
    logic [LAT-1:0]         tag_v;
    logic [LAT-1:0][IW-1:0] tag_id;

    // Search upward from the priority pointer, wrapping at N_REQ-1.
    always_comb begin
        int idx;
        idx       = 0;
        scan_idx  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            scan_idx = IW'(idx);
            if (!gnt_found && req_if.req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        xfer             = gnt_found && !hold && rst_n;
        req_if.req_ready = '0;
        mul_a            = '0;
        mul_b            = '0;
        if (xfer) begin
            req_if.req_ready[gnt_idx] = 1'b1;
            mul_a                     = req_if.req_a[gnt_idx];
            mul_b                     = req_if.req_b[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr              <= '0;
            tag_v            <= '0;
            tag_id           <= '0;
            req_if.rsp_valid <= '0;
            req_if.rsp_data  <= '0;
`ifdef FPARB_PERF_EN
            perf_issue_cnt   <= '0;
            perf_stall_cnt   <= '0;
`endif
        end else begin
            if (xfer) ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

            for (int s = LAT - 1; s > 0; s--) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            tag_v[0]  <= xfer;
            tag_id[0] <= gnt_idx;

            // The last tag stage lines up with mul_result; register it as the response.
            req_if.rsp_valid <= '0;
            if (tag_v[LAT-1]) begin
                req_if.rsp_valid[tag_id[LAT-1]] <= 1'b1;
                req_if.rsp_data                 <= mul_result;
            end
`ifdef FPARB_PERF_EN
            if (xfer && (perf_issue_cnt != 32'hFFFF_FFFF))
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((|req_if.req_valid) && !xfer && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
        end
    end

    assign idle = !(|tag_v) && !(|req_if.rsp_valid);

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter (N_REQ=3, LAT=2): directed scenarios plus a randomized run
// checked against a queue-based reference model of grants and responses.
module tb_fpmul_arbiter;
    localparam int N_REQ = 3;
    localparam int LAT   = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [XLEN-1:0] mul_a, mul_b, mul_result;
    logic            idle;
`ifdef FPARB_PERF_EN
    logic [31:0]     perf_issue_cnt, perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fpmul_arbiter_if #(.N_REQ(N_REQ), .XLEN(XLEN)) bus ();

    fpmul_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .req_if         (bus),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_result     (mul_result),
        .idle           (idle)
`ifdef FPARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Normal-range single-precision multiply, truncating; enough to give distinct results.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'($urandom_range(100, 150));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [XLEN-1:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= fmul(mul_a, mul_b);
        for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
    end
    assign mul_result = mp[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_a[i] = rand_fp();
            bus.req_b[i] = rand_fp();
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        hold          = 1'b0;
        bus.req_valid = '0;
        rand_operands();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        hold          = 1'b0;
        bus.req_valid = 3'b111;
        rand_operands();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
        total++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
            bad++; $display("FAIL reset_mul got a=%h b=%h exp=0", mul_a, mul_b);
        end
        total++;
        if (bus.rsp_valid !== 3'b000 || bus.rsp_data !== 32'd0) begin
            bad++; $display("FAIL reset_rsp got v=%b d=%h exp=000/0", bus.rsp_valid, bus.rsp_data);
        end
        total++;
        if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            rand_operands();
            bus.req_valid = (c == 5) ? 3'b010 : 3'b000;
            if (c == 5) begin
                bus.req_a[1] = 32'h4000_0000;
                bus.req_b[1] = 32'h4040_0000;
            end
            @(negedge clk);
            total++;
            if (bus.req_ready !== ((c == 5) ? 3'b010 : 3'b000)) begin
                bad++; $display("FAIL single_ready c=%0d got=%b", c, bus.req_ready);
            end
            if (c == 5) begin
                total++;
                if (mul_a !== 32'h4000_0000 || mul_b !== 32'h4040_0000) begin
                    bad++; $display("FAIL single_mul got a=%h b=%h exp=40000000/40400000", mul_a, mul_b);
                end
            end
            total++;
            if (bus.rsp_valid !== ((c == 8) ? 3'b010 : 3'b000)) begin
                bad++; $display("FAIL single_rsp_valid c=%0d got=%b", c, bus.rsp_valid);
            end
            if (c == 8) begin
                total++;
                if (bus.rsp_data !== 32'h40C0_0000) begin
                    bad++; $display("FAIL single_rsp_data got=%h exp=40c00000", bus.rsp_data);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_r;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            rand_operands();
            bus.req_valid = 3'b111;
            @(negedge clk);
            exp_r = 3'b001 << (c % 3);
            total++;
            if (bus.req_ready !== exp_r) begin
                bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r);
            end
            exp_r = (c >= 3) ? (3'b001 << ((c - 3) % 3)) : 3'b000;
            total++;
            if (bus.rsp_valid !== exp_r) begin
                bad++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_r);
            end
            step();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_hold();
        logic [2:0] exp_r;
        logic       exp_i;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            rand_operands();
            bus.req_valid = (c <= 9) ? 3'b111 : 3'b000;
            hold          = (c >= 2 && c <= 9);
            @(negedge clk);
            exp_r = (c < 2) ? (3'b001 << c) : 3'b000;
            total++;
            if (bus.req_ready !== exp_r) begin
                bad++; $display("FAIL hold_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r);
            end
            exp_r = (c == 3) ? 3'b001 : (c == 4) ? 3'b010 : 3'b000;
            total++;
            if (bus.rsp_valid !== exp_r) begin
                bad++; $display("FAIL hold_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_r);
            end
            exp_i = (c == 0 || c >= 5);
            total++;
            if (idle !== exp_i) begin
                bad++; $display("FAIL hold_idle c=%0d got=%b exp=%b", c, idle, exp_i);
            end
`ifdef FPARB_PERF_EN
            if (c == 10) begin
                total++;
                if (perf_issue_cnt !== 32'd2 || perf_stall_cnt !== 32'd8) begin
                    bad++; $display("FAIL hold_perf got issue=%0d stall=%0d exp=2/8", perf_issue_cnt, perf_stall_cnt);
                end
            end
`endif
            step();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_flush();
        logic [2:0] exp_r;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            rand_operands();
            rst_n         = (c != 1);
            bus.req_valid = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : (c == 4) ? 3'b111 : 3'b000;
            @(negedge clk);
            exp_r = (c == 0 || c == 4) ? 3'b001 : 3'b000;
            total++;
            if (bus.req_ready !== exp_r) begin
                bad++; $display("FAIL flush_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r);
            end
            if (c == 1) begin
                total++;
                if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
                    bad++; $display("FAIL flush_mul got a=%h b=%h exp=0", mul_a, mul_b);
                end
            end
            exp_r = (c == 7) ? 3'b001 : 3'b000;
            total++;
            if (bus.rsp_valid !== exp_r) begin
                bad++; $display("FAIL flush_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_r);
            end
            step();
        end
    endtask

    task automatic test_rr_skip();
        logic [2:0] exp_r;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            rand_operands();
            bus.req_valid = (c <= 2) ? 3'b100 : 3'b101;
            @(negedge clk);
            exp_r = (c == 3) ? 3'b001 : 3'b100;
            total++;
            if (bus.req_ready !== exp_r) begin
                bad++; $display("FAIL skip_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r);
            end
            step();
        end
        bus.req_valid = '0;
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] d;
    } rsp_t;

    task automatic test_random();
        rsp_t        q[$];
        rsp_t        e;
        int          mptr;
        int          g;
        int          n_issue;
        int          n_stall;
        logic [2:0]  exp_ready, exp_rv;
        logic [31:0] exp_d, exp_a, exp_b;
        logic        exp_i;
        mptr    = 0;
        n_issue = 0;
        n_stall = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_operands();
            bus.req_valid = 3'($urandom);
            hold          = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            exp_rv = 3'b000;
            exp_d  = 32'd0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e      = q.pop_front();
                exp_rv = 3'b001 << e.id;
                exp_d  = e.d;
            end
            exp_i = (exp_rv == 3'b000) && (q.size() == 0);
            g = -1;
            if (!hold)
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && bus.req_valid[(mptr + k) % N_REQ]) g = (mptr + k) % N_REQ;
            exp_ready = 3'b000;
            exp_a     = 32'd0;
            exp_b     = 32'd0;
            if (g >= 0) begin
                exp_ready = 3'b001 << g;
                exp_a     = bus.req_a[g];
                exp_b     = bus.req_b[g];
                q.push_back('{due: cyc + LAT + 1, id: g, d: fmul(exp_a, exp_b)});
                mptr = (g + 1) % N_REQ;
                n_issue++;
            end else if (bus.req_valid != 3'b000) begin
                n_stall++;
            end
            total++;
            if (bus.req_ready !== exp_ready) begin
                bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            total++;
            if (mul_a !== exp_a || mul_b !== exp_b) begin
                bad++; $display("FAIL rand_mul c=%0d got a=%h b=%h exp a=%h b=%h", cyc, mul_a, mul_b, exp_a, exp_b);
            end
            total++;
            if (bus.rsp_valid !== exp_rv) begin
                bad++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rv);
            end
            if (exp_rv != 3'b000) begin
                total++;
                if (bus.rsp_data !== exp_d) begin
                    bad++; $display("FAIL rand_rsp_data c=%0d got=%h exp=%h", cyc, bus.rsp_data, exp_d);
                end
            end
            total++;
            if (idle !== exp_i) begin
                bad++; $display("FAIL rand_idle c=%0d got=%b exp=%b", cyc, idle, exp_i);
            end
            step();
        end
        bus.req_valid = '0;
        hold          = 1'b0;
`ifdef FPARB_PERF_EN
        @(negedge clk);
        total++;
        if (perf_issue_cnt !== 32'(n_issue) || perf_stall_cnt !== 32'(n_stall)) begin
            bad++; $display("FAIL rand_perf got issue=%0d stall=%0d exp=%0d/%0d", perf_issue_cnt, perf_stall_cnt, n_issue, n_stall);
        end
`endif
        repeat (LAT + 2) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        hold          = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_reset_flush();
        test_rr_skip();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
